led_blink_ctrl: RTL
===================

LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, clk cycles per tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter WIDTH, default 9, LED bus width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port address  input  2  Avalon slave register select.
REQ-006 SHALL have port chipselect  input  1  Avalon slave select.
REQ-007 SHALL have port write_n  input  1  Avalon write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon write data.
REQ-009 SHALL have port readdata  output  32  Avalon read data, combinational, zero-latency.
REQ-010 SHALL have port data_in  input  WIDTH  LED word from the green-LED PIO out_port.
REQ-011 SHALL have port led_out  output  WIDTH  conditioned LED drive to the board pins.

Function
REQ-012 SHALL decode the register map:
- addr0 MASK[WIDTH-1:0] RW
- addr1 HALF_PERIOD[15:0] RW, in ticks
- addr2 CTRL RW: bit0 EN; bit1 RESTART, write-1 self-clearing, reads 0
- addr3 STATUS RO: bit0 PHASE, bits[31:16] current tick count
REQ-013 SHALL perform a write when chipselect=1 and write_n=0; writes to addr3 ignored; unused writedata bits ignored.
REQ-014 SHALL zero-extend readdata; unused bits read 0.
REQ-015 SHALL, when active (EN=1 and HALF_PERIOD!=0), run a prescaler 0..PRESCALE-1 and emit a 1-cycle tick on the cycle it wraps to 0.
REQ-016 SHALL, on each tick, increment the tick count; if the count equals HALF_PERIOD-1, set count to 0 and toggle PHASE.
REQ-017 SHALL, when inactive (EN=0 or HALF_PERIOD=0), hold prescaler=0, count=0, PHASE=1.
REQ-018 SHALL reset prescaler and count to 0 and set PHASE=1 on the cycle after any write to HALF_PERIOD or a RESTART=1 write.
REQ-019 SHALL give a write/restart precedence over a simultaneous tick or toggle.
REQ-020 SHALL register led_out = data_in & (~MASK | {WIDTH{PHASE}}), giving 1-cycle latency from data_in to led_out.
REQ-021 SHALL make unmasked bits follow data_in exactly (1-cycle delay) regardless of EN.
REQ-022 SHALL update MASK and EN writes into led_out no later than the 2nd clk edge after the write edge.
REQ-023 SHALL toggle a masked, lit bit with full period 2*HALF_PERIOD*PRESCALE cycles, duty 50%.

Reset
REQ-024 SHALL, while reset_n=0 at a clk edge, clear MASK=0, HALF_PERIOD=0, EN=0, prescaler=0, count=0, led_out=0, and set PHASE=1.
REQ-025 SHALL take effect on reset asserted mid-blink at the next edge; after release, led_out follows data_in 1 cycle later.
REQ-026 SHALL have readdata reflect the reset register values in the same cycle reset is applied.

Verification (PRESCALE=4)
REQ-027 Scenario: reset, data_in=9'h1FF -> led_out=0 during reset, 9'h1FF one cycle after release; all reads 0 except STATUS=1.
REQ-028 Scenario: MASK=9'h001, HALF_PERIOD=2, EN=1, data_in=9'h1FF -> bit0 high 8 cycles, low 8, repeating; bits 8:1 constant 1.
REQ-029 Scenario: as above, data_in bit0=0 -> bit0 stays 0 throughout; STATUS.PHASE still toggles every 8 cycles.
REQ-030 Scenario: RESTART written on the exact cycle of a toggle tick -> PHASE=1, count=0 next cycle; no toggle occurs.
REQ-031 Scenario: HALF_PERIOD=0 with EN=1 -> led_out equals data_in delayed 1 cycle; STATUS reads 1.
REQ-032 Scenario: HALF_PERIOD 16'hFFFF written, read back -> 32'h0000FFFF; count wraps only at 16'hFFFE.

Source files
------------

// File: rtl/led_blink_ctrl.sv
// rtl/led_blink_ctrl.sv - Avalon-controlled LED blink/mask conditioner
//
// Sits between the green-LED PIO and the board pins. Bits selected by MASK
// blink with a programmable half period (in prescaler ticks). Unmasked bits
// pass through with one register of delay.
//
// Ports:
//   clk         single clock, rising edge
//   reset_n     synchronous active-low reset
//   address     register select (0 MASK, 1 HALF_PERIOD, 2 CTRL, 3 STATUS)
//   chipselect  slave select
//   write_n     write strobe, active-low
//   writedata   write data
//   readdata    combinational read data for the selected register
//   data_in     LED word from the PIO
//   led_out     conditioned, registered LED drive
module led_blink_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int WIDTH    = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] led_out
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [15:0]      half_q,  half_d;
    logic             en_q,    en_d;
    logic [PW-1:0]    pre_q,   pre_d;
    logic [15:0]      cnt_q,   cnt_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] led_q,   led_d;

    logic wr_en, wr_mask, wr_half, wr_ctrl;
    logic restart, active, tick, wrap;

    assign wr_en   = chipselect & ~write_n;
    assign wr_mask = wr_en && (address == 2'd0);
    assign wr_half = wr_en && (address == 2'd1);
    assign wr_ctrl = wr_en && (address == 2'd2);

    // Any HALF_PERIOD write restarts the blink so a new period starts clean.
    assign restart = wr_half | (wr_ctrl & writedata[1]);
    assign active  = en_q && (half_q != 16'd0);
    assign tick    = active && (pre_q == PRE_MAX);
    assign wrap    = tick && (cnt_q == (half_q - 16'd1));

    always_comb begin
        mask_d  = mask_q;
        half_d  = half_q;
        en_d    = en_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;

        if (wr_mask) mask_d = writedata[WIDTH-1:0];
        if (wr_half) half_d = writedata[15:0];
        if (wr_ctrl) en_d   = writedata[0];

        // Restart and idle both park the timebase; restart wins over a
        // tick or toggle landing on the same edge.
        if (restart || !active) begin
            pre_d   = '0;
            cnt_d   = '0;
            phase_d = 1'b1;
        end else begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (wrap) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else if (tick) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Masked bits are gated by PHASE; unmasked bits always pass.
    always_comb begin
        led_d = data_in & (~mask_q | {WIDTH{phase_q}});
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q  <= '0;
            half_q  <= '0;
            en_q    <= 1'b0;
            pre_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            led_q   <= '0;
        end else begin
            mask_q  <= mask_d;
            half_q  <= half_d;
            en_q    <= en_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led_out = led_q;

    // While reset is held, present the post-reset register image so a read
    // in the reset cycle already sees cleared values.
    always_comb begin
        readdata = 32'd0;
        if (!reset_n) begin
            if (address == 2'd3) readdata = 32'd1;
        end else begin
            case (address)
                2'd0:    readdata = 32'(mask_q);
                2'd1:    readdata = {16'd0, half_q};
                2'd2:    readdata = {31'd0, en_q};
                default: readdata = {cnt_q, 15'd0, phase_q};
            endcase
        end
    end

endmodule
